memory_arbiter_nch: RTL and testbench

//  Parametrised N-channel arbiter between cache miss/writeback ports and the single external memory port.

---
 rtl/memory_arbiter_nch.sv | 191 +++++++++++++++++++
 tb/tb_memory_arbiter_nch.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_arbiter_nch.sv
// rtl/memory_arbiter_nch.sv - N-channel arbiter between cache miss/writeback ports and the external memory port
module memory_arbiter_nch #(
    parameter int NUM_CH         = 4,
    parameter int ADDR_W         = 24,
    parameter int BLOCK_WORDS    = 4,
    parameter int ARB_MODE       = 0,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                     clock_i,
    input  logic                     resetn_i,
    input  logic [NUM_CH-1:0]        ch_req_i,
    input  logic [NUM_CH-1:0]        ch_reqBlock_i,
    input  logic [NUM_CH-1:0]        ch_rw_i,
    input  logic [NUM_CH*ADDR_W-1:0] ch_add_i,
    input  logic [NUM_CH*32-1:0]     ch_data_i,
    output logic [31:0]              ch_data_o,
    output logic [NUM_CH-1:0]        ch_valid_o,
    output logic [NUM_CH-1:0]        ch_ready_o,
    output logic [NUM_CH-1:0]        ch_done_o,
    output logic [NUM_CH-1:0]        grant_o,
    output logic                     mem_req_o,
    output logic                     mem_reqBlock_o,
    output logic                     mem_rw_o,
    output logic [ADDR_W-1:0]        mem_add_o,
    output logic [31:0]              mem_data_o,
    input  logic [31:0]              mem_data_i,
    input  logic                     mem_ready_i,
    input  logic                     mem_valid_i,
    input  logic                     mem_done_i,
    output logic [1:0]               exception_o
);

    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    // Counter must reach BLOCK_WORDS+1 so a surplus beat is distinguishable from a full block
    localparam int CNT_W = $clog2(BLOCK_WORDS + 2);
    localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 2);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_XFER,
        ST_DONE
    } state_t;

    state_t            state;
    logic [IDX_W-1:0]  g_idx;
    logic [IDX_W-1:0]  rr_ptr;
    logic [IDX_W-1:0]  win_idx;
    logic [IDX_W-1:0]  cand;
    logic              win_found;
    logic              lat_rw;
    logic              lat_block;
    logic [CNT_W-1:0]  beat_cnt;
    logic [CNT_W-1:0]  beat_next;
    logic [CNT_W-1:0]  exp_beats;
    logic [WD_W-1:0]   wd_cnt;
    logic              in_xfer;
    logic              beat_raw;
    logic              beat_fwd;
    logic              wd_expire;

    logic [ADDR_W-1:0] add_arr   [NUM_CH];
    logic [31:0]       wdata_arr [NUM_CH];

    for (genvar k = 0; k < NUM_CH; k++) begin : g_unpack
        assign add_arr[k]   = ch_add_i[k*ADDR_W +: ADDR_W];
        assign wdata_arr[k] = ch_data_i[k*32 +: 32];
    end

    assign in_xfer   = (state == ST_XFER);
    assign exp_beats = lat_block ? CNT_W'(BLOCK_WORDS) : CNT_W'(1);

    // A beat is a write-accept or a read-valid; the other strobe is meaningless for the direction
    assign beat_raw  = in_xfer && (lat_rw ? mem_ready_i : mem_valid_i);
    // Only the first exp_beats beats reach the channel; extras still count toward the mismatch check
    assign beat_fwd  = beat_raw && (beat_cnt < exp_beats);
    assign beat_next = (beat_raw && (beat_cnt != '1)) ? beat_cnt + CNT_W'(1) : beat_cnt;

    // Watchdog fires when the idle run in XFER reaches TIMEOUT_CYCLES; zero disables it
    assign wd_expire = (TIMEOUT_CYCLES != 0) && in_xfer && !beat_raw &&
                       ((32'(wd_cnt) + 32'd1) == 32'(TIMEOUT_CYCLES));

    // Winner selection: rotating search after rr_ptr, or lowest set index in fixed mode
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        if (ARB_MODE == 1) begin
            for (int i = NUM_CH - 1; i >= 0; i--) begin
                if (ch_req_i[i]) begin
                    win_found = 1'b1;
                    win_idx   = IDX_W'(i);
                end
            end
        end else begin
            for (int i = 1; i <= NUM_CH; i++) begin
                cand = IDX_W'((32'(rr_ptr) + 32'(i)) % 32'(NUM_CH));
                if (!win_found && ch_req_i[cand]) begin
                    win_found = 1'b1;
                    win_idx   = cand;
                end
            end
        end
    end

    // Zero-latency data paths between memory and the granted channel
    always_comb begin
        ch_data_o  = '0;
        ch_valid_o = '0;
        ch_ready_o = '0;
        mem_data_o = '0;
        if ((state == ST_ISSUE) || in_xfer) begin
            mem_data_o = wdata_arr[g_idx];
        end
        if (in_xfer && !lat_rw) begin
            ch_data_o         = mem_data_i;
            ch_valid_o[g_idx] = beat_fwd;
        end
        if (in_xfer && lat_rw) begin
            ch_ready_o[g_idx] = beat_fwd;
        end
    end

    // Transaction FSM with registered grant, request strobe, latched fields and sticky exceptions
    always_ff @(posedge clock_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state          <= ST_IDLE;
            g_idx          <= '0;
            rr_ptr         <= IDX_W'(NUM_CH - 1);
            lat_rw         <= 1'b0;
            lat_block      <= 1'b0;
            beat_cnt       <= '0;
            wd_cnt         <= '0;
            grant_o        <= '0;
            ch_done_o      <= '0;
            mem_req_o      <= 1'b0;
            mem_reqBlock_o <= 1'b0;
            mem_rw_o       <= 1'b0;
            mem_add_o      <= '0;
            exception_o    <= 2'b00;
        end else begin
            mem_req_o <= 1'b0;
            ch_done_o <= '0;
            case (state)
                ST_IDLE: begin
                    if (win_found && mem_ready_i) begin
                        g_idx          <= win_idx;
                        lat_rw         <= ch_rw_i[win_idx];
                        lat_block      <= ch_reqBlock_i[win_idx];
                        mem_rw_o       <= ch_rw_i[win_idx];
                        mem_reqBlock_o <= ch_reqBlock_i[win_idx];
                        mem_add_o      <= add_arr[win_idx];
                        mem_req_o      <= 1'b1;
                        grant_o        <= NUM_CH'(1) << win_idx;
                        state          <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    rr_ptr   <= g_idx;
                    beat_cnt <= '0;
                    wd_cnt   <= '0;
                    state    <= ST_XFER;
                end
                ST_XFER: begin
                    beat_cnt <= beat_next;
                    wd_cnt   <= beat_raw ? '0 : wd_cnt + WD_W'(1);
                    if (mem_done_i) begin
                        if (beat_next != exp_beats) begin
                            exception_o[0] <= 1'b1;
                        end
                        ch_done_o <= NUM_CH'(1) << g_idx;
                        state     <= ST_DONE;
                    end else if (wd_expire) begin
                        exception_o[1] <= 1'b1;
                        ch_done_o      <= NUM_CH'(1) << g_idx;
                        state          <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    grant_o <= '0;
                    state   <= ST_IDLE;
                end
                default: begin
                    grant_o <= '0;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_memory_arbiter_nch.sv
// tb/tb_memory_arbiter_nch.sv - directed self-checking bench for memory_arbiter_nch
module tb_memory_arbiter_nch;

    logic         clk;
    logic         rst_n;
    logic [3:0]   req_a;
    logic [3:0]   req_b;
    logic [3:0]   blk;
    logic [3:0]   rw;
    logic [95:0]  add;
    logic [127:0] wdat;
    logic [31:0]  mem_rdata;
    logic         mem_ready;
    logic         mem_valid;
    logic         mem_done;

    logic [31:0]  dat_a, dat_b, mwd_a, mwd_b;
    logic [3:0]   vld_a, vld_b, rdy_a, rdy_b, done_a, done_b, gnt_a, gnt_b;
    logic         mreq_a, mreq_b, mblk_a, mblk_b, mrw_a, mrw_b;
    logic [23:0]  madd_a, madd_b;
    logic [1:0]   exc_a, exc_b;

    int n_checks = 0;
    int n_errors = 0;
    int done_cnt_a [4];

    memory_arbiter_nch #(
        .NUM_CH(4), .ADDR_W(24), .BLOCK_WORDS(4), .ARB_MODE(0), .TIMEOUT_CYCLES(16)
    ) dut_rr (
        .clock_i(clk), .resetn_i(rst_n),
        .ch_req_i(req_a), .ch_reqBlock_i(blk), .ch_rw_i(rw), .ch_add_i(add), .ch_data_i(wdat),
        .ch_data_o(dat_a), .ch_valid_o(vld_a), .ch_ready_o(rdy_a), .ch_done_o(done_a),
        .grant_o(gnt_a), .mem_req_o(mreq_a), .mem_reqBlock_o(mblk_a), .mem_rw_o(mrw_a),
        .mem_add_o(madd_a), .mem_data_o(mwd_a), .mem_data_i(mem_rdata),
        .mem_ready_i(mem_ready), .mem_valid_i(mem_valid), .mem_done_i(mem_done),
        .exception_o(exc_a)
    );

    memory_arbiter_nch #(
        .NUM_CH(4), .ADDR_W(24), .BLOCK_WORDS(4), .ARB_MODE(1), .TIMEOUT_CYCLES(16)
    ) dut_fp (
        .clock_i(clk), .resetn_i(rst_n),
        .ch_req_i(req_b), .ch_reqBlock_i(blk), .ch_rw_i(rw), .ch_add_i(add), .ch_data_i(wdat),
        .ch_data_o(dat_b), .ch_valid_o(vld_b), .ch_ready_o(rdy_b), .ch_done_o(done_b),
        .grant_o(gnt_b), .mem_req_o(mreq_b), .mem_reqBlock_o(mblk_b), .mem_rw_o(mrw_b),
        .mem_add_o(madd_b), .mem_data_o(mwd_b), .mem_data_i(mem_rdata),
        .mem_ready_i(mem_ready), .mem_valid_i(mem_valid), .mem_done_i(mem_done),
        .exception_o(exc_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (done_a[i]) done_cnt_a[i]++;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req(input bit use_b, input int budget, output int lat);
        lat = -1;
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            if ((use_b ? mreq_b : mreq_a) == 1'b1) begin
                lat = n;
                break;
            end
        end
        check("req_seen", lat >= 0, 1);
    endtask

    task automatic rd_single(input bit use_b, input int k, input logic [31:0] d, input bit drop);
        logic [3:0] oh;
        oh = 4'b0001 << k;
        cyc();
        mem_valid = 1'b1;
        mem_done  = 1'b1;
        mem_rdata = d;
        @(negedge clk);
        check("rd_valid", use_b ? vld_b : vld_a, oh);
        check("rd_data", use_b ? dat_b : dat_a, d);
        check("req_pulse_width", use_b ? mreq_b : mreq_a, 0);
        cyc();
        mem_valid = 1'b0;
        mem_done  = 1'b0;
        @(negedge clk);
        check("rd_done", use_b ? done_b : done_a, oh);
        if (drop) begin
            if (use_b) req_b[k] = 1'b0;
            else       req_a[k] = 1'b0;
        end
    endtask

    initial begin
        int lat;
        int done_at;
        int pulses;
        bit seq [5];

        rst_n = 1'b0; req_a = '0; req_b = '0; blk = '0; rw = '0;
        add = {24'h000180, 24'h000100, 24'h000080, 24'h000000};
        wdat = '0; mem_rdata = '0; mem_ready = 1'b0; mem_valid = 1'b0; mem_done = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_grant", gnt_a, 0);
        check("rst_mem_req", mreq_a, 0);
        check("rst_exc", exc_a, 0);
        check("rst_done", done_a, 0);
        check("rst_add", madd_a, 0);

        // Round-robin: all four request single reads together
        cyc();
        rst_n = 1'b1; mem_ready = 1'b1; req_a = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            wait_req(1'b0, 10, lat);
            if (k == 0) check("arb_latency", lat, 1);
            check("t1_grant", gnt_a, 4'b0001 << k);
            check("t1_add", madd_a, 24'h80 * k);
            check("t1_rw", mrw_a, 0);
            rd_single(1'b0, k, 32'hC0DE_0000 + k, 1'b1);
        end
        cyc();
        for (int k = 0; k < 4; k++) check("t1_done_once", done_cnt_a[k], 1);

        // Fixed priority: ch1 keeps winning over ch3 until it drops
        req_b = 4'b1010;
        for (int r = 0; r < 3; r++) begin
            wait_req(1'b1, 10, lat);
            check("t3_grant_ch1", gnt_b, 4'b0010);
            check("t3_add", madd_b, 24'h80);
            rd_single(1'b1, 1, 32'h3300_0000 + r, r == 2);
        end
        wait_req(1'b1, 10, lat);
        check("t3_grant_ch3", gnt_b, 4'b1000);
        rd_single(1'b1, 3, 32'h3300_0003, 1'b1);
        cyc();

        // Block read on ch2 at 0x100
        blk = 4'b0100; req_a = 4'b0100;
        wait_req(1'b0, 10, lat);
        check("t2_grant", gnt_a, 4'b0100);
        check("t2_add", madd_a, 24'h100);
        check("t2_blk", mblk_a, 1);
        for (int i = 0; i < 4; i++) begin
            cyc();
            mem_valid = 1'b1;
            mem_rdata = 32'hA0 + i;
            @(negedge clk);
            check("t2_valid", vld_a, 4'b0100);
            check("t2_data", dat_a, 32'hA0 + i);
        end
        cyc();
        mem_valid = 1'b0; mem_done = 1'b1;
        @(negedge clk);
        check("t2_valid_end", vld_a, 0);
        cyc();
        mem_done = 1'b0;
        @(negedge clk);
        check("t2_done", done_a, 4'b0100);
        check("t2_exc", exc_a, 0);
        req_a = '0; blk = '0;

        // Block write on ch1 with ready pattern 1,0,1,1,1
        cyc();
        seq = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        rw = 4'b0010; blk = 4'b0010; req_a = 4'b0010;
        wdat[63:32] = 32'hB000_0000;
        wait_req(1'b0, 10, lat);
        check("t4_grant", gnt_a, 4'b0010);
        check("t4_rw", mrw_a, 1);
        check("t4_wdata_issue", mwd_a, 32'hB000_0000);
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            mem_ready = seq[i];
            wdat[63:32] = 32'hB000_0000 + i;
            @(negedge clk);
            check("t4_ready", rdy_a, {2'b00, seq[i], 1'b0});
            check("t4_wdata", mwd_a, 32'hB000_0000 + i);
            if (rdy_a[1]) pulses++;
        end
        check("t4_pulses", pulses, 4);
        cyc();
        mem_ready = 1'b0; mem_done = 1'b1;
        @(negedge clk);
        check("t4_ready_end", rdy_a, 0);
        cyc();
        mem_ready = 1'b1; mem_done = 1'b0;
        @(negedge clk);
        check("t4_done", done_a, 4'b0010);
        check("t4_exc", exc_a, 0);
        req_a = '0; rw = '0; blk = '0;

        // Watchdog: memory silent after issue
        cyc();
        req_a = 4'b1000;
        wait_req(1'b0, 10, lat);
        done_at = -1;
        for (int i = 1; i <= 20; i++) begin
            cyc();
            @(negedge clk);
            if (done_a != 0) begin
                done_at = i;
                break;
            end
        end
        check("t5_done_lat", done_at, 17);
        check("t5_done_ch", done_a, 4'b1000);
        check("t5_exc", exc_a, 2'b10);
        req_a = 4'b0001;
        wait_req(1'b0, 10, lat);
        check("t5_next_grant", gnt_a, 4'b0001);
        rd_single(1'b0, 0, 32'h5555_0000, 1'b1);

        // Single read with a surplus beat
        cyc();
        req_a = 4'b0010;
        wait_req(1'b0, 10, lat);
        cyc();
        mem_valid = 1'b1; mem_rdata = 32'h11;
        @(negedge clk);
        check("t6_beat1", vld_a, 4'b0010);
        check("t6_data1", dat_a, 32'h11);
        cyc();
        mem_rdata = 32'h22;
        @(negedge clk);
        check("t6_beat2_dropped", vld_a, 0);
        cyc();
        mem_valid = 1'b0; mem_done = 1'b1;
        cyc();
        mem_done = 1'b0;
        @(negedge clk);
        check("t6_done", done_a, 4'b0010);
        check("t6_exc", exc_a, 2'b11);
        req_a = '0;

        // Asynchronous reset in the middle of XFER
        cyc();
        req_a = 4'b0001;
        wait_req(1'b0, 10, lat);
        cyc();
        mem_valid = 1'b1; mem_rdata = 32'h77;
        #1;
        check("rst_pre_valid", vld_a, 4'b0001);
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_grant", gnt_a, 0);
        check("arst_valid", vld_a, 0);
        check("arst_data", dat_a, 0);
        check("arst_exc", exc_a, 0);
        check("arst_add", madd_a, 0);
        mem_valid = 1'b0; req_a = '0;
        cyc();
        rst_n = 1'b1;
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
